// File: rtl/dmem_responder.sv
// ============================================================================
//  Module   : dmem_responder
//  Brief    : Wait-state data-memory responder with an internal word SRAM.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module dmem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_2000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          c_addr_w   = $clog2(DEPTH_WORDS);
    localparam logic [32:0] c_limit    = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);
    localparam logic [3:0]  c_cnt_load = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    // S_ACCESS is the single SRAM cycle; it keeps the response LATENCY+1 edges after accept.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic                r_req_ready;
    logic [3:0]          r_cnt;
    logic [31:0]         r_addr;
    logic                r_we;
    logic [3:0]          r_be;
    logic [31:0]         r_wdata;
    logic                r_rsp_valid;
    logic [31:0]         r_rsp_rdata;
    logic                r_rsp_err;
    logic [31:0]         r_mem [DEPTH_WORDS];

    logic                w_accept;
    logic                w_err;
    logic [c_addr_w-1:0] w_index;

    assign w_accept = req_valid & r_req_ready;
    assign w_err    = (r_addr[1:0] != 2'b00) | (r_addr < BASE_ADDR) | ({1'b0, r_addr} >= c_limit);
    // BASE_ADDR is aligned to the array size, so the low address bits are the word index.
    assign w_index  = r_addr[c_addr_w+1:2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = (LATENCY > 0) ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = S_ACCESS;
                end
            end
            S_ACCESS: w_state_next = S_RESP;
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_req_ready <= 1'b0;
            r_cnt       <= 4'd0;
            r_addr      <= 32'd0;
            r_we        <= 1'b0;
            r_be        <= 4'd0;
            r_wdata     <= 32'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_req_ready <= (w_state_next == S_IDLE);
            if (w_accept) begin
                r_cnt   <= c_cnt_load;
                r_addr  <= req_addr;
                r_we    <= req_we;
                r_be    <= req_be;
                r_wdata <= req_wdata;
            end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (r_state == S_ACCESS) begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= w_err;
                r_rsp_rdata <= (!r_we && !w_err) ? r_mem[w_index] : 32'd0;
            end else if (r_state == S_RESP && rsp_ready) begin
                r_rsp_valid <= 1'b0;
                r_rsp_err   <= 1'b0;
                r_rsp_rdata <= 32'd0;
            end
        end
    end

    // Array is deliberately not reset; the write is gated by state so reset aborts it.
    always_ff @(posedge clk) begin
        if (r_state == S_ACCESS && r_we && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (r_be[b]) begin
                    r_mem[w_index][8*b +: 8] <= r_wdata[8*b +: 8];
                end
            end
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
//  Module   : tb_dmem_responder
//  Brief    : Scoreboard bench for dmem_responder (LATENCY 2, 0 and 15).
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dmem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid, req_we, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    logic [1:0]  a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready, a_rsp_err;
    logic [31:0] a_rsp_rdata [2];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    dmem_responder #(.LATENCY(LAT)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_we(req_we), .req_be(req_be), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.LATENCY(0)) u_l0 (
        .clk(clk), .reset(reset),
        .req_valid(a_req_valid[0]), .req_ready(a_req_ready[0]), .req_addr(req_addr),
        .req_we(req_we), .req_be(req_be), .req_wdata(req_wdata),
        .rsp_valid(a_rsp_valid[0]), .rsp_ready(a_rsp_ready[0]), .rsp_rdata(a_rsp_rdata[0]),
        .rsp_err(a_rsp_err[0])
    );

    dmem_responder #(.LATENCY(15)) u_l15 (
        .clk(clk), .reset(reset),
        .req_valid(a_req_valid[1]), .req_ready(a_req_ready[1]), .req_addr(req_addr),
        .req_we(req_we), .req_be(req_be), .req_wdata(req_wdata),
        .rsp_valid(a_rsp_valid[1]), .rsp_ready(a_rsp_ready[1]), .rsp_rdata(a_rsp_rdata[1]),
        .rsp_err(a_rsp_err[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one response is consumed per handshake edge.
    always @(negedge clk) begin
        if (reset && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rdata 0x%08h err %0b with nothing expected",
                         rsp_rdata, rsp_err);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
            end
        end
    end

    task automatic wait_accept(input logic rdy_src_sel, input int s);
        int k;
        k = 0;
        while (!(rdy_src_sel ? a_req_ready[s] : req_ready) && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (!(rdy_src_sel ? a_req_ready[s] : req_ready)) begin
            $display("FAIL accept_timeout: got req_ready 0 expected 1");
            $fatal(1, "request never accepted");
        end
    endtask

    task automatic do_req(input logic [31:0] addr, input logic we, input logic [3:0] be,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input logic exp_err, input int hold);
        exp_t e;
        int   k;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        sb.push_back(e);
        rsp_ready = (hold == 0);
        @(negedge clk);
        req_addr = addr; req_we = we; req_be = be; req_wdata = wdata; req_valid = 1'b1;
        wait_accept(1'b0, 0);
        @(posedge clk);
        #1;
        // Scramble the request bus to prove it was captured at accept.
        req_valid = 1'b0; req_addr = ~addr; req_we = ~we; req_be = ~be; req_wdata = ~wdata;
        k = 0;
        while (!rsp_valid && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("latency", k, LAT + 1);
        for (int i = 0; i < hold; i++) begin
            check("bp_valid", {31'd0, rsp_valid}, 32'd1);
            check("bp_rdata", rsp_rdata, exp_rdata);
            check("bp_err", {31'd0, rsp_err}, {31'd0, exp_err});
            check("bp_req_ready", {31'd0, req_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("post_hs_valid", {31'd0, rsp_valid}, 32'd0);
        check("post_hs_req_ready", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic aux_req(input int s, input logic [31:0] addr, input logic we,
                           input logic [31:0] wdata, input logic [31:0] exp_rdata,
                           input int exp_lat);
        int k;
        a_rsp_ready[s] = 1'b1;
        @(negedge clk);
        req_addr = addr; req_we = we; req_be = 4'hF; req_wdata = wdata;
        a_req_valid[s] = 1'b1;
        wait_accept(1'b1, s);
        @(posedge clk);
        #1;
        a_req_valid[s] = 1'b0;
        k = 0;
        while (!a_rsp_valid[s] && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        check($sformatf("aux%0d_latency", s), k, exp_lat);
        check($sformatf("aux%0d_rdata", s), a_rsp_rdata[s], exp_rdata);
        check($sformatf("aux%0d_err", s), {31'd0, a_rsp_err[s]}, 32'd0);
        @(posedge clk);
        #1;
        check($sformatf("aux%0d_post_hs_valid", s), {31'd0, a_rsp_valid[s]}, 32'd0);
    endtask

    initial begin
        int k;
        req_valid = 1'b0; req_we = 1'b0; req_be = 4'h0; req_addr = 32'd0; req_wdata = 32'd0;
        rsp_ready = 1'b1; a_req_valid = 2'b00; a_rsp_ready = 2'b11;

        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("first_req_ready", {31'd0, req_ready}, 32'd1);

        do_req(32'h2000, 1'b1, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0, 0);
        do_req(32'h2000, 1'b0, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0, 0);
        do_req(32'h2004, 1'b1, 4'hF, 32'h11223344, 32'h0, 1'b0, 0);
        do_req(32'h2004, 1'b1, 4'b0101, 32'hAABBCCDD, 32'h0, 1'b0, 0);
        do_req(32'h2004, 1'b0, 4'h0, 32'h0, 32'h11BB33DD, 1'b0, 0);
        do_req(32'h2002, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 0);
        do_req(32'h3000, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 0);
        do_req(32'h2FFC, 1'b1, 4'hF, 32'hCAFEF00D, 32'h0, 1'b0, 0);
        do_req(32'h1FFC, 1'b1, 4'hF, 32'hFFFFFFFF, 32'h0, 1'b1, 0);
        do_req(32'h2002, 1'b1, 4'hF, 32'hFFFFFFFF, 32'h0, 1'b1, 0);
        do_req(32'h2000, 1'b1, 4'h0, 32'h0, 32'h0, 1'b0, 0);
        do_req(32'h2FFC, 1'b0, 4'h0, 32'h0, 32'hCAFEF00D, 1'b0, 0);
        do_req(32'h2000, 1'b0, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0, 0);
        do_req(32'h2004, 1'b0, 4'h0, 32'h0, 32'h11BB33DD, 1'b0, 5);

        // Reset during WAIT of a store must abandon it without a response.
        do_req(32'h2008, 1'b1, 4'hF, 32'h01020304, 32'h0, 1'b0, 0);
        @(negedge clk);
        req_addr = 32'h2008; req_we = 1'b1; req_be = 4'hF; req_wdata = 32'h55555555;
        req_valid = 1'b1;
        wait_accept(1'b0, 0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("mid_rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("mid_rst_rsp_rdata", rsp_rdata, 32'd0);
        check("mid_rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("mid_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_req_ready_back", {31'd0, req_ready}, 32'd1);
        do_req(32'h2008, 1'b0, 4'h0, 32'h0, 32'h01020304, 1'b0, 0);

        aux_req(0, 32'h2010, 1'b1, 32'h0BADC0DE, 32'h0, 1);
        aux_req(0, 32'h2010, 1'b0, 32'h0, 32'h0BADC0DE, 1);
        aux_req(1, 32'h2010, 1'b1, 32'h600DF00D, 32'h0, 16);
        aux_req(1, 32'h2010, 1'b0, 32'h0, 32'h600DF00D, 16);

        k = 0;
        while (sb.size() != 0 && k < 20) begin
            @(posedge clk);
            k++;
        end
        check("scoreboard_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
